// File: rtl/expr_tx.sv
// expr_tx: serialises a latched arithmetic expression (single decimal digits
// separated by '+' or '*') into an ASCII byte stream, one byte per transfer.
//
// Handshake: a byte moves on every rising edge where out_valid and out_ready
// are both high. out_valid is registered, never looks at out_ready
// combinationally, and once raised stays high with out_char frozen until the
// byte is taken.
//
// Optional feature macro: EXPR_TX_TERM_EN -- when defined, an '=' (0x3D)
// terminator is sent as one extra handshaked byte after the last digit.
//
// dbg_state exposes the FSM state register (0 IDLE, 1 DIGIT, 2 OP, 3 TERM).
module expr_tx #(
  parameter int MAX_TERMS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(MAX_TERMS+1)-1:0] num_terms,
  input  logic [4*MAX_TERMS-1:0]         digits,
  input  logic [MAX_TERMS-2:0]           ops,
  output logic [7:0]                     out_char,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [1:0]                     dbg_state
);

  localparam int NW = $clog2(MAX_TERMS+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIGIT = 2'd1,
    S_OP    = 2'd2
`ifdef EXPR_TX_TERM_EN
    ,
    S_TERM  = 2'd3
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [NW-1:0]          idx_q, idx_d;
  logic [NW-1:0]          n_q, n_d;
  logic [4*MAX_TERMS-1:0] dig_q, dig_d;
  logic [MAX_TERMS-2:0]   ops_q, ops_d;
  logic                   done_d, err_d;
  logic                   load_ok;
  logic                   xfer;
  logic [NW-1:0]          idx_m1;
  logic [3:0]             cur_digit;
  logic                   cur_op;
  logic [7:0]             char_d;

  assign xfer      = out_valid & out_ready;
  assign dbg_state = state_q;

  // Load check: operand count in range and every used operand a decimal digit.
  always_comb begin
    load_ok = (num_terms != '0) && (num_terms <= NW'(MAX_TERMS));
    for (int i = 0; i < MAX_TERMS; i++) begin
      if ((NW'(i) < num_terms) && (digits[4*i +: 4] > 4'd9)) load_ok = 1'b0;
    end
  end

  // Next state: snapshot on a valid load, advance only on a transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    dig_d   = dig_q;
    ops_d   = ops_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (load_ok) begin
            dig_d   = digits;
            ops_d   = ops;
            n_d     = num_terms;
            idx_d   = '0;
            state_d = S_DIGIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DIGIT: begin
        if (xfer) begin
          if (idx_q == n_q - NW'(1)) begin
`ifdef EXPR_TX_TERM_EN
            state_d = S_TERM;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = S_OP;
            idx_d   = idx_q + NW'(1);
          end
        end
      end
      S_OP: begin
        if (xfer) state_d = S_DIGIT;
      end
`ifdef EXPR_TX_TERM_EN
      S_TERM: begin
        if (xfer) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Character for the next cycle, decoded from next-state values so the
  // output byte is a plain register. In OP, idx has already moved past the
  // left operand, so the operator is ops[idx-1].
  always_comb begin
    idx_m1    = idx_d - NW'(1);
    cur_digit = 4'd0;
    cur_op    = 1'b0;
    for (int i = 0; i < MAX_TERMS; i++) begin
      if (idx_d == NW'(i)) cur_digit = dig_d[4*i +: 4];
    end
    for (int i = 0; i < MAX_TERMS-1; i++) begin
      if (idx_m1 == NW'(i)) cur_op = ops_d[i];
    end
    char_d = 8'h00;
    case (state_d)
      S_DIGIT: char_d = {4'h3, cur_digit};
      S_OP:    char_d = cur_op ? 8'h2A : 8'h2B;
`ifdef EXPR_TX_TERM_EN
      S_TERM:  char_d = 8'h3D;
`endif
      default: char_d = 8'h00;
    endcase
  end

  // State, snapshot and all outputs are registered; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      dig_q     <= '0;
      ops_q     <= '0;
      out_char  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      dig_q     <= dig_d;
      ops_q     <= ops_d;
      out_char  <= char_d;
      out_valid <= (state_d != S_IDLE);
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_expr_tx.sv
// Bench for expr_tx: table of directed loads, hand-written corner sequences
// (backpressure, start while busy, reset mid-stream) and randomized loads,
// all checked against a character-queue model of the expression format.
module tb_expr_tx;

`ifdef EXPR_TX_TERM_EN
  localparam int TERM = 1;
`else
  localparam int TERM = 0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_terms = '0;
  logic [31:0] digits = '0;
  logic [6:0]  ops = '0;
  logic [7:0]  out_char;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done, err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  expr_tx #(.MAX_TERMS(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
    .digits(digits), .ops(ops), .out_char(out_char), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  bit         mon_en = 1'b0;
  bit         rand_rdy = 1'b0;
  bit         pending_done = 1'b0;
  bit         hold_pending = 1'b0;
  logic [7:0] hold_char = '0;
  logic [7:0] exp_q[$];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: the expected byte stream of an expression.
  function automatic bit model_push(int nt, logic [31:0] dg, logic [6:0] op);
    bit ok;
    ok = (nt >= 1) && (nt <= 8);
    if (ok) begin
      for (int i = 0; i < nt; i++) if (dg[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    if (ok) begin
      for (int i = 0; i < nt; i++) begin
        exp_q.push_back(8'h30 + {4'h0, dg[4*i +: 4]});
        if (i < nt - 1) exp_q.push_back(op[i] ? 8'h2A : 8'h2B);
      end
      if (TERM == 1) exp_q.push_back(8'h3D);
    end
    return ok;
  endfunction

  // Random sink readiness, changed only just after a rising edge.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every observed byte must be the next expected one.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!out_valid) check("idle_char", {24'h0, out_char}, 32'h0);
      check("busy_eq_valid", {31'h0, busy}, {31'h0, out_valid});
      check("done", {31'h0, done}, {31'h0, pending_done});
      if (done) done_cnt++;
      pending_done = 1'b0;
      check("no_bubble", {31'h0, out_valid}, {31'h0, (exp_q.size() != 0)});
      if (hold_pending) begin
        check("hold_valid", {31'h0, out_valid}, 32'h1);
        check("hold_char", {24'h0, out_char}, {24'h0, hold_char});
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        check("stream_char", {24'h0, out_char}, {24'h0, exp_q.pop_front()});
        xfer_cnt++;
        if (exp_q.size() == 0) pending_done = 1'b1;
      end
      hold_pending = out_valid && !out_ready;
      hold_char    = out_char;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_load(input int nt, input logic [31:0] dg, input logic [6:0] op,
                         input bit stall);
    bit ok;
    logic [7:0] first;
    @(posedge clk); #1;
    start = 1'b1; num_terms = 4'(nt); digits = dg; ops = op;
    @(posedge clk); #1;
    start = 1'b0; num_terms = 4'($urandom); digits = $urandom; ops = 7'($urandom);
    ok = model_push(nt, dg, op);
    first = 8'h30 + {4'h0, dg[3:0]};
    @(negedge clk);
    check("load_err", {31'h0, err}, {31'h0, !ok});
    check("load_valid", {31'h0, out_valid}, {31'h0, ok});
    check("load_busy", {31'h0, busy}, {31'h0, ok});
    if (ok) check("first_char", {24'h0, out_char}, {24'h0, first});
    @(posedge clk); #1;
    if (stall) out_ready = 1'b0;
    @(negedge clk);
    check("err_pulse", {31'h0, err}, 32'h0);
  endtask

  task automatic wait_idle(input int budget);
    bit fin;
    fin = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0 && !out_valid && !pending_done) fin = 1'b1;
    end
    check("idle_timeout", {31'h0, fin}, 32'h1);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          nt;
    logic [31:0] dg;
    logic [6:0]  op;
    bit          exp_err;
    int          exp_len;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int x0, d0;
    vecs[0] = '{3, 32'h0000_0321, 7'b0000010, 1'b0, 5};
    vecs[1] = '{1, 32'h0000_0009, 7'b0000000, 1'b0, 1};
    vecs[2] = '{2, 32'h0000_00A5, 7'b0000000, 1'b1, 0};
    vecs[3] = '{0, 32'h0000_0012, 7'b0000000, 1'b1, 0};
    vecs[4] = '{8, 32'h9876_5432, 7'b1010101, 1'b0, 15};
    vecs[5] = '{9, 32'h0000_0000, 7'b0000000, 1'b1, 0};
    vecs[6] = '{2, 32'hFFFF_FF07, 7'b1111111, 1'b0, 3};
    vecs[7] = '{8, 32'hA123_4567, 7'b0000000, 1'b1, 0};

    // reset state
    #2;
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_char", {24'h0, out_char}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // table-driven loads with out_ready held high
    for (int v = 0; v < 8; v++) begin
      x0 = xfer_cnt; d0 = done_cnt;
      do_load(vecs[v].nt, vecs[v].dg, vecs[v].op, 1'b0);
      wait_idle(100);
      check($sformatf("vec%0d_len", v), xfer_cnt - x0,
            vecs[v].exp_err ? 0 : vecs[v].exp_len + TERM);
      check($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_err ? 0 : 1);
    end

    // backpressure: '+' held for 3 cycles
    x0 = xfer_cnt;
    do_load(3, 32'h0000_0321, 7'b0000010, 1'b1);
    check("bp_char", {24'h0, out_char}, 32'h2B);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle(100);
    check("bp_len", xfer_cnt - x0, 5 + TERM);

    // start pulsed while busy is ignored
    x0 = xfer_cnt;
    do_load(3, 32'h0000_0456, 7'b0000001, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; num_terms = 4'd2; digits = 32'h0000_0088; ops = 7'b1111111;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_start_err", {31'h0, err}, 32'h0);
    wait_idle(100);
    check("busy_start_len", xfer_cnt - x0, 5 + TERM);

    // reset during the second character
    do_load(3, 32'h0000_0321, 7'b0000010, 1'b0);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
    check("mid_rst_char", {24'h0, out_char}, 32'h0);
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    exp_q.delete();
    pending_done = 1'b0;
    hold_pending = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", {31'h0, done}, 32'h0);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    x0 = xfer_cnt; d0 = done_cnt;
    do_load(2, 32'h0000_0047, 7'b0000001, 1'b0);
    wait_idle(100);
    check("post_rst_len", xfer_cnt - x0, 3 + TERM);
    check("post_rst_done", done_cnt - d0, 1);

    // randomized loads with random backpressure
    rand_rdy = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int nt;
      logic [31:0] dg;
      nt = $urandom_range(0, 9);
      for (int i = 0; i < 8; i++)
        dg[4*i +: 4] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15))
                                                    : 4'($urandom_range(0, 9));
      do_load(nt, dg, 7'($urandom), 1'b0);
      wait_idle(400);
    end
    rand_rdy = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
